// File: rtl/pb_conditioner.sv
// Multi-channel pushbutton front end: synchronizer, debouncer and edge / auto-repeat
// pulse generator feeding the alarm-clock FSM key inputs.
module pb_conditioner #(
    parameter int   N_CH            = 4,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter int   REPEAT_DELAY    = 16,
    parameter int   REPEAT_PERIOD   = 4,
    parameter logic IDLE_LVL        = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sig,
    input  logic [1:0]      mode,
    output logic [N_CH-1:0] stable,
    output logic [N_CH-1:0] pulse,
    output logic [N_CH-1:0] held
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    logic [SYNC_STAGES-1:0] sync_q    [N_CH];
    logic [DB_W-1:0]        db_cnt    [N_CH];
    logic [RPT_W-1:0]       rpt_cnt   [N_CH];
    rpt_state_t             rpt_state [N_CH];

    logic [N_CH-1:0] s_lvl;
    logic [N_CH-1:0] toggle;
    logic [N_CH-1:0] press_evt;
    logic [N_CH-1:0] rel_evt;
    logic [N_CH-1:0] edge_evt;
    logic [N_CH-1:0] rpt_fire;

    // Events that will take effect at the coming edge; release suppresses any repeat pulse.
    always_comb begin
        s_lvl     = '0;
        toggle    = '0;
        press_evt = '0;
        rel_evt   = '0;
        edge_evt  = '0;
        rpt_fire  = '0;
        for (int i = 0; i < N_CH; i++) begin
            s_lvl[i]     = sync_q[i][SYNC_STAGES-1];
            toggle[i]    = (s_lvl[i] != stable[i]) && (db_cnt[i] == DB_LAST);
            press_evt[i] = toggle[i] && (stable[i] == IDLE_LVL);
            rel_evt[i]   = toggle[i] && (stable[i] != IDLE_LVL);
            case (mode)
                2'b00:   edge_evt[i] = toggle[i] && !stable[i];
                2'b01:   edge_evt[i] = toggle[i] && stable[i];
                2'b10:   edge_evt[i] = toggle[i];
                default: edge_evt[i] = press_evt[i];
            endcase
            rpt_fire[i] = (mode == 2'b11) && !rel_evt[i] &&
                          (((rpt_state[i] == RPT_DELAY)  && (rpt_cnt[i] == DELAY_LAST)) ||
                           ((rpt_state[i] == RPT_REPEAT) && (rpt_cnt[i] == PERIOD_LAST)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                sync_q[i]    <= {SYNC_STAGES{IDLE_LVL}};
                db_cnt[i]    <= '0;
                rpt_cnt[i]   <= '0;
                rpt_state[i] <= RPT_IDLE;
            end
            stable <= {N_CH{IDLE_LVL}};
            pulse  <= '0;
            held   <= '0;
        end else begin
            pulse <= edge_evt | rpt_fire;
            for (int i = 0; i < N_CH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], sig[i]};

                if (s_lvl[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (toggle[i]) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end

                // Leaving auto-repeat mode or releasing the key abandons any repeat in flight.
                if ((mode != 2'b11) || rel_evt[i]) begin
                    rpt_state[i] <= RPT_IDLE;
                    rpt_cnt[i]   <= '0;
                    held[i]      <= 1'b0;
                end else begin
                    case (rpt_state[i])
                        RPT_IDLE: begin
                            held[i] <= 1'b0;
                            if (press_evt[i]) begin
                                rpt_state[i] <= RPT_DELAY;
                                rpt_cnt[i]   <= '0;
                            end
                        end
                        RPT_DELAY: begin
                            if (rpt_cnt[i] == DELAY_LAST) begin
                                rpt_state[i] <= RPT_REPEAT;
                                rpt_cnt[i]   <= '0;
                                held[i]      <= 1'b1;
                            end else begin
                                rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                            end
                        end
                        RPT_REPEAT: begin
                            held[i] <= 1'b1;
                            if (rpt_cnt[i] == PERIOD_LAST) begin
                                rpt_cnt[i] <= '0;
                            end else begin
                                rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                            end
                        end
                        default: begin
                            rpt_state[i] <= RPT_IDLE;
                            rpt_cnt[i]   <= '0;
                            held[i]      <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner: hand-derived vector table for the directed scenarios plus
// a randomized run compared every cycle against a windowed/age-based reference model.
module tb_pb_conditioner;

    localparam int   N_CH = 4;
    localparam int   SS   = 2;
    localparam int   DB   = 4;
    localparam int   RD   = 16;
    localparam int   RP   = 4;
    localparam logic IDLE_LVL = 1'b1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] sig;
    logic [1:0]      mode;
    logic [N_CH-1:0] stable;
    logic [N_CH-1:0] pulse;
    logic [N_CH-1:0] held;

    int n_vec = 0;
    int n_err = 0;

    pb_conditioner #(
        .N_CH(N_CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .IDLE_LVL(IDLE_LVL)
    ) dut (
        .clk(clk), .rst(rst), .sig(sig), .mode(mode),
        .stable(stable), .pulse(pulse), .held(held)
    );

    always #5 clk = ~clk;

    // Reference model: s is sig delayed SS edges, a level is accepted once the last DB
    // samples all disagree with it, and repeats are timed from the age of the press.
    logic [N_CH-1:0] m_stable = {N_CH{IDLE_LVL}};
    logic [N_CH-1:0] m_pulse  = '0;
    logic [N_CH-1:0] m_held   = '0;
    logic [N_CH-1:0] pipe [$];
    logic [N_CH-1:0] win  [$];
    int              age  [N_CH];

    always @(posedge clk) begin
        logic [N_CH-1:0] s_now;
        logic            old, tog, all_diff, press, rel, ep, rp, hd;
        if (rst) begin
            pipe.delete();
            win.delete();
            for (int k = 0; k < SS; k++) pipe.push_back({N_CH{IDLE_LVL}});
            for (int k = 0; k < DB; k++) win.push_back({N_CH{IDLE_LVL}});
            m_stable = {N_CH{IDLE_LVL}};
            m_pulse  = '0;
            m_held   = '0;
            for (int c = 0; c < N_CH; c++) age[c] = -1;
        end else begin
            s_now = pipe.pop_front();
            pipe.push_back(sig);
            win.push_back(s_now);
            if (win.size() > DB) void'(win.pop_front());
            for (int c = 0; c < N_CH; c++) begin
                all_diff = 1'b1;
                foreach (win[j]) if (win[j][c] == m_stable[c]) all_diff = 1'b0;
                old   = m_stable[c];
                tog   = all_diff;
                press = tog && (old == IDLE_LVL);
                rel   = tog && (old != IDLE_LVL);
                case (mode)
                    2'd0:    ep = tog && (old == 1'b0);
                    2'd1:    ep = tog && (old == 1'b1);
                    2'd2:    ep = tog;
                    default: ep = press;
                endcase
                rp = 1'b0;
                hd = 1'b0;
                if (mode != 2'd3 || rel) begin
                    age[c] = -1;
                end else if (age[c] >= 0) begin
                    age[c] = age[c] + 1;
                    rp = (age[c] == RD) || (age[c] > RD && ((age[c] - RD) % RP) == 0);
                    hd = (age[c] >= RD);
                end
                if (press && mode == 2'd3) age[c] = 0;
                m_pulse[c] = ep | rp;
                m_held[c]  = hd;
                if (tog) m_stable[c] = ~old;
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic [N_CH-1:0] s, input logic [1:0] m);
        rst  = r;
        sig  = s;
        mode = m;
    endtask

    task automatic checkOutput(input string tag, input logic [N_CH-1:0] e_st,
                               input logic [N_CH-1:0] e_pu, input logic [N_CH-1:0] e_he);
        n_vec++;
        if (stable !== e_st || pulse !== e_pu || held !== e_he) begin
            n_err++;
            $display("[TB] FAIL %s @%0t: got stable=%h pulse=%h held=%h, want stable=%h pulse=%h held=%h",
                     tag, $time, stable, pulse, held, e_st, e_pu, e_he);
        end
    endtask

    always @(posedge clk) begin
        #1;
        checkOutput("model", m_stable, m_pulse, m_held);
    end

    typedef struct {
        logic            r;
        logic [N_CH-1:0] s;
        logic [1:0]      m;
        int              cyc;
        logic [N_CH-1:0] st;
        logic [N_CH-1:0] pu;
        logic [N_CH-1:0] he;
    } vec_t;

    vec_t tbl [$];

    initial begin
        logic [N_CH-1:0] cur_sig;
        logic [1:0]      cur_mode;
        logic            cur_rst;
        int              rate;

        // Reset / idle, then mode 01 press and release
        tbl.push_back('{1'b1, 4'hF, 2'd0,  3, 4'hF, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hF, 2'd0, 20, 4'hF, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hE, 2'd1,  5, 4'hF, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hE, 2'd1,  1, 4'hE, 4'h1, 4'h0});
        tbl.push_back('{1'b0, 4'hE, 2'd1,  1, 4'hE, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hF, 2'd1,  6, 4'hF, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hF, 2'd1,  3, 4'hF, 4'h0, 4'h0});
        // Glitch of 3 rejected, 4 accepted
        tbl.push_back('{1'b0, 4'hD, 2'd1,  3, 4'hF, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hF, 2'd1, 10, 4'hF, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hD, 2'd1,  4, 4'hF, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hF, 2'd1,  2, 4'hD, 4'h2, 4'h0});
        tbl.push_back('{1'b0, 4'hF, 2'd1,  1, 4'hD, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hF, 2'd1, 10, 4'hF, 4'h0, 4'h0});
        // Mode 10, two channels together
        tbl.push_back('{1'b0, 4'h3, 2'd2,  5, 4'hF, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'h3, 2'd2,  1, 4'h3, 4'hC, 4'h0});
        tbl.push_back('{1'b0, 4'h3, 2'd2,  1, 4'h3, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'h3, 2'd2, 13, 4'h3, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hF, 2'd2,  5, 4'h3, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hF, 2'd2,  1, 4'hF, 4'hC, 4'h0});
        tbl.push_back('{1'b0, 4'hF, 2'd2,  1, 4'hF, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hF, 2'd2, 10, 4'hF, 4'h0, 4'h0});
        // Mode 11 auto-repeat on ch2: pulses at P, P+16, P+20, ...
        tbl.push_back('{1'b0, 4'hB, 2'd3,  6, 4'hB, 4'h4, 4'h0});
        tbl.push_back('{1'b0, 4'hB, 2'd3, 15, 4'hB, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hB, 2'd3,  1, 4'hB, 4'h4, 4'h4});
        tbl.push_back('{1'b0, 4'hB, 2'd3,  1, 4'hB, 4'h0, 4'h4});
        tbl.push_back('{1'b0, 4'hB, 2'd3,  3, 4'hB, 4'h4, 4'h4});
        tbl.push_back('{1'b0, 4'hB, 2'd3,  4, 4'hB, 4'h4, 4'h4});
        tbl.push_back('{1'b0, 4'hB, 2'd3,  8, 4'hB, 4'h4, 4'h4});
        tbl.push_back('{1'b0, 4'hF, 2'd3,  4, 4'hB, 4'h4, 4'h4});
        tbl.push_back('{1'b0, 4'hF, 2'd3,  2, 4'hF, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hF, 2'd3,  3, 4'hF, 4'h0, 4'h0});
        // Abort by mode change, then by reset
        tbl.push_back('{1'b0, 4'hB, 2'd3,  6, 4'hB, 4'h4, 4'h0});
        tbl.push_back('{1'b0, 4'hB, 2'd3, 16, 4'hB, 4'h4, 4'h4});
        tbl.push_back('{1'b0, 4'hB, 2'd3,  2, 4'hB, 4'h0, 4'h4});
        tbl.push_back('{1'b0, 4'hB, 2'd0,  1, 4'hB, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hB, 2'd3, 10, 4'hB, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hF, 2'd3,  6, 4'hF, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hB, 2'd3,  6, 4'hB, 4'h4, 4'h0});
        tbl.push_back('{1'b0, 4'hB, 2'd3, 17, 4'hB, 4'h0, 4'h4});
        tbl.push_back('{1'b1, 4'hB, 2'd3,  1, 4'hF, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hB, 2'd3,  5, 4'hF, 4'h0, 4'h0});
        tbl.push_back('{1'b0, 4'hB, 2'd3,  1, 4'hB, 4'h4, 4'h0});
        tbl.push_back('{1'b0, 4'hB, 2'd3, 17, 4'hB, 4'h0, 4'h4});
        tbl.push_back('{1'b0, 4'hF, 2'd3, 10, 4'hF, 4'h0, 4'h0});

        applyStimulus(1'b1, 4'hF, 2'd0);
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].r, tbl[i].s, tbl[i].m);
            repeat (tbl[i].cyc) @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d", i), tbl[i].st, tbl[i].pu, tbl[i].he);
        end

        $display("[TB] directed table done, starting random phase");
        cur_sig  = 4'hF;
        cur_mode = 2'd3;
        rate     = 20;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(2))
                    0:       rate = 3;
                    1:       rate = 20;
                    default: rate = 64;
                endcase
            end
            for (int b = 0; b < N_CH; b++)
                if ($urandom_range(rate - 1) == 0) cur_sig[b] = ~cur_sig[b];
            if ($urandom_range(99) == 0)
                cur_mode = ($urandom_range(1) == 0) ? 2'd3 : 2'($urandom_range(3));
            cur_rst = ($urandom_range(499) == 0);
            applyStimulus(cur_rst, cur_sig, cur_mode);
            @(posedge clk);
            #1;
        end

        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
